demux_1_to_4_reg: RTL

// - Registered 1-to-4 stream demultiplexer: routes one N-bit operand to one of four lanes on 2-bit select.
// - Opposite direction of the 4-to-1 operand mux in the FPU datapath; fans operands out to four FPU units.
// - Valid/ready on input and on every lane; one-entry output slot per lane; per-lane wrapping transfer counters.

---
 rtl/demux_1_to_4_reg_pkg.sv | 18 +
 rtl/demux_out_slot.sv | 72 +++++++
 rtl/demux_1_to_4_reg.sv | 58 +++++
 3 files changed

// File: rtl/demux_1_to_4_reg_pkg.sv
// Shared definitions for the registered 1-to-4 operand demultiplexer:
// lane indices, lane count and the per-slot state encoding.
package demux_1_to_4_reg_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;

    localparam logic [LANE_W-1:0] LANE_A = 2'b00;
    localparam logic [LANE_W-1:0] LANE_B = 2'b01;
    localparam logic [LANE_W-1:0] LANE_C = 2'b10;
    localparam logic [LANE_W-1:0] LANE_D = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : demux_1_to_4_reg_pkg

// File: rtl/demux_out_slot.sv
// One-entry output register slice for a single lane, with a wrapping
// counter of completed output handshakes.
module demux_out_slot
    import demux_1_to_4_reg_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [N-1:0]     din,
    output logic             valid,
    input  logic             ready,
    output logic [N-1:0]     dout,
    output logic [CNT_W-1:0] cnt
);

    slot_state_t      state_r;
    slot_state_t      state_next_s;
    logic [N-1:0]     data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             drain_s;

    assign drain_s = (state_r == SLOT_FULL) & ready;

    // Next-state logic; a drain and a load in the same cycle keep the slot full.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next_s = SLOT_FULL;
                end else begin
                    state_next_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (drain_s & ~load) begin
                    state_next_s = SLOT_EMPTY;
                end else begin
                    state_next_s = SLOT_FULL;
                end
            end
            default: begin
                state_next_s = SLOT_EMPTY;
            end
        endcase
    end

    // Slot state, held data and handshake counter; reset discards held data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SLOT_EMPTY;
            data_r  <= {N{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (load) begin
                data_r <= din;
            end
            if (drain_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign valid = (state_r == SLOT_FULL);
    assign dout  = data_r;
    assign cnt   = cnt_r;

endmodule : demux_out_slot

// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 stream demultiplexer: routes an N-bit operand to one of
// four valid/ready lanes, each backed by a one-entry slot and transfer counter.
module demux_1_to_4_reg
    import demux_1_to_4_reg_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANE_W-1:0]          in_sel,
    input  logic [N-1:0]               in_data,
    output logic [NUM_LANES-1:0]       out_valid,
    input  logic [NUM_LANES-1:0]       out_ready,
    output logic [N-1:0]               out_a,
    output logic [N-1:0]               out_b,
    output logic [N-1:0]               out_c,
    output logic [N-1:0]               out_d,
    output logic [NUM_LANES*CNT_W-1:0] xfer_cnt,
    output logic                       idle
);

    logic [NUM_LANES-1:0] load_s;
    logic [N-1:0]         dout_s [NUM_LANES];
    logic [CNT_W-1:0]     cnt_s  [NUM_LANES];

    // Only the selected lane can stall the input; a draining slot can reload.
    assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign load_s[k] = in_valid & in_ready & (in_sel == LANE_W'(k));

        demux_out_slot #(
            .N     (N),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_s[k]),
            .din   (in_data),
            .valid (out_valid[k]),
            .ready (out_ready[k]),
            .dout  (dout_s[k]),
            .cnt   (cnt_s[k])
        );

        assign xfer_cnt[k*CNT_W +: CNT_W] = cnt_s[k];
    end

    assign out_a = dout_s[LANE_A];
    assign out_b = dout_s[LANE_B];
    assign out_c = dout_s[LANE_C];
    assign out_d = dout_s[LANE_D];
    assign idle  = ~|out_valid;

endmodule : demux_1_to_4_reg
